// File: rtl/cmp_pkg.sv
// Shared state and cascade encodings for the nibble-serial comparator sequencer.
package cmp_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] CASC_GT = 3'b100;
  localparam logic [2:0] CASC_EQ = 3'b010;
  localparam logic [2:0] CASC_LT = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  function automatic logic is_onehot3(input logic [2:0] c);
    return (c == CASC_GT) || (c == CASC_EQ) || (c == CASC_LT);
  endfunction
endpackage

// File: rtl/nibble_sel.sv
// Combinational selector: nibble idx of a NIBBLES*4-bit word.
module nibble_sel #(
  parameter int NIBBLES = 4,
  parameter int IW      = 2
) (
  input  logic [4*NIBBLES-1:0] word,
  input  logic [IW-1:0]        idx,
  output logic [3:0]           nib
);
  generate
    if (NIBBLES == 1) begin : g_one
      assign nib = word;
    end else begin : g_mux
      logic [NIBBLES-1:0][3:0] w;
      assign w   = word;
      assign nib = w[idx];
    end
  endgenerate
endmodule

// File: rtl/nibble_cmp_seq.sv
// Drives an external 4-bit cascade comparator slice one nibble per clock, MSB first,
// feeding its registered verdict back as the next cascade; stops once a nibble decides.
module nibble_cmp_seq
  import cmp_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic                 res_gt,
  output logic                 res_eq,
  output logic                 res_lt,
  output logic [3:0]           nib_a,
  output logic [3:0]           nib_b,
  output logic                 casc_gt,
  output logic                 casc_eq,
  output logic                 casc_lt,
  input  logic                 cmp_gt,
  input  logic                 cmp_eq,
  input  logic                 cmp_lt
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx;
  logic [1:0][W-1:0]    op_q;   // [0]=A, [1]=B
  logic [1:0][3:0]      nib;
  logic [2:0]           casc_q, res_q, cap, casc;
  logic                 last;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_sel
      nibble_sel #(.NIBBLES(NIBBLES), .IW(IW)) u_sel (
        .word (op_q[g]),
        .idx  (idx),
        .nib  (nib[g])
      );
    end
  endgenerate

  // Illegal slice codes collapse to LT, which also terminates the run.
  assign cap  = is_onehot3({cmp_gt, cmp_eq, cmp_lt}) ? {cmp_gt, cmp_eq, cmp_lt} : CASC_LT;
  assign last = (cap != CASC_EQ) || (idx == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      op_q   <= '0;
      casc_q <= CASC_EQ;
      res_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          op_q   <= {op_b, op_a};
          idx    <= IW'(NIBBLES - 1);
          casc_q <= CASC_EQ;
        end
        S_RUN: begin
          casc_q <= cap;
          // Result lands on the edge into DONE so it is visible alongside done.
          if (last) res_q <= cap;
          else      idx   <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign casc    = (state == S_IDLE) ? CASC_EQ : casc_q;
  assign nib_a   = (state == S_IDLE) ? 4'h0 : nib[0];
  assign nib_b   = (state == S_IDLE) ? 4'h0 : nib[1];
  assign casc_gt = casc[2];
  assign casc_eq = casc[1];
  assign casc_lt = casc[0];
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign res_gt  = res_q[2];
  assign res_eq  = res_q[1];
  assign res_lt  = res_q[0];
endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Bench: sequencer wired to a behavioural 4-bit cascade slice, 4-nibble and 1-nibble builds.
module tb_nibble_cmp_seq;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- 4-nibble instance ----------------
  logic        start0;
  logic [15:0] a0, b0;
  logic        busy0, done0, rgt0, req0, rlt0;
  logic [3:0]  na0, nb0;
  logic        cg0, ce0, cl0, sg0, se0, sl0;

  nibble_cmp_seq #(.NIBBLES(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op_a(a0), .op_b(b0),
    .busy(busy0), .done(done0), .res_gt(rgt0), .res_eq(req0), .res_lt(rlt0),
    .nib_a(na0), .nib_b(nb0), .casc_gt(cg0), .casc_eq(ce0), .casc_lt(cl0),
    .cmp_gt(sg0), .cmp_eq(se0), .cmp_lt(sl0)
  );

  // ---------------- 1-nibble instance ----------------
  logic       start1;
  logic [3:0] a1, b1;
  logic       busy1, done1, rgt1, req1, rlt1;
  logic [3:0] na1, nb1;
  logic       cg1, ce1, cl1, sg1, se1, sl1;

  nibble_cmp_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1),
    .busy(busy1), .done(done1), .res_gt(rgt1), .res_eq(req1), .res_lt(rlt1),
    .nib_a(na1), .nib_b(nb1), .casc_gt(cg1), .casc_eq(ce1), .casc_lt(cl1),
    .cmp_gt(sg1), .cmp_eq(se1), .cmp_lt(sl1)
  );

  function automatic logic [2:0] slice(input logic [3:0] x, y, input logic [2:0] c);
    if (x > y)      return 3'b100;
    else if (x < y) return 3'b001;
    else if (c == 3'b100 || c == 3'b010 || c == 3'b001) return c;
    else            return 3'b001;
  endfunction

  always_comb {sg0, se0, sl0} = slice(na0, nb0, {cg0, ce0, cl0});
  always_comb {sg1, se1, sl1} = slice(na1, nb1, {cg1, ce1, cl1});

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  res;
    int          k;
  } vec_t;

  // Runs one operation on dut0; returns done-cycle index (1 = first cycle after
  // the start-sampling edge) and the cascade values seen during RUN.
  task automatic run0(input logic [15:0] a, input logic [15:0] b,
                      output int cyc, output int runs, output logic [2:0] cs [4]);
    @(negedge clk);
    a0 = a; b0 = b; start0 = 1;
    @(negedge clk);
    start0 = 0;
    cyc = 1; runs = 0;
    for (int i = 0; i < 4; i++) cs[i] = 3'b000;
    while (!done0 && cyc < 40) begin
      if (busy0 && runs < 4) cs[runs] = {cg0, ce0, cl0};
      runs++;
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t vt [10];
  int cyc, runs;
  logic [2:0] cs [4];

  initial begin
    vt[0] = '{16'h1234, 16'h1234, 3'b010, 4};
    vt[1] = '{16'h9000, 16'h8FFF, 3'b100, 1};
    vt[2] = '{16'h0001, 16'h0002, 3'b001, 4};
    vt[3] = '{16'hFFFF, 16'h0000, 3'b100, 1};
    vt[4] = '{16'h1200, 16'h1300, 3'b001, 2};
    vt[5] = '{16'h12F0, 16'h1200, 3'b100, 3};
    vt[6] = '{16'hABCD, 16'hABCE, 3'b001, 4};
    vt[7] = '{16'h0000, 16'h0000, 3'b010, 4};
    vt[8] = '{16'h00A1, 16'h00A0, 3'b100, 4};
    vt[9] = '{16'hFFFF, 16'hFFFF, 3'b010, 4};

    rst = 1; start0 = 0; start1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_res",  {rgt0, req0, rlt0}, 0);
    chk("rst_casc", {cg0, ce0, cl0}, 3'b010);
    chk("rst_nib",  {na0, nb0}, 0);
    rst = 0;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      run0(vt[v].a, vt[v].b, cyc, runs, cs);
      chk($sformatf("v%0d_done_cycle", v), cyc, vt[v].k + 1);
      chk($sformatf("v%0d_res", v), {rgt0, req0, rlt0}, vt[v].res);
      chk($sformatf("v%0d_busy_done", v), busy0, 1);
      @(negedge clk);
      chk($sformatf("v%0d_idle", v), {busy0, done0}, 0);
      chk($sformatf("v%0d_hold", v), {rgt0, req0, rlt0}, vt[v].res);
      if (v == 2)
        for (int i = 0; i < 4; i++) chk($sformatf("v2_casc%0d", i), cs[i], 3'b010);
    end

    // Start during RUN with different operands: ignored.
    @(negedge clk);
    a0 = 16'h5555; b0 = 16'h5555; start0 = 1;
    @(negedge clk);
    start0 = 0;
    @(negedge clk);
    a0 = 16'hFFFF; b0 = 16'h0000; start0 = 1;
    @(negedge clk);
    start0 = 0;
    chk("ign_busy", busy0, 1);
    cyc = 3;
    while (!done0 && cyc < 40) begin
      chk("ign_busy_run", busy0, 1);
      @(negedge clk); cyc++;
    end
    chk("ign_done_cycle", cyc, 5);
    chk("ign_res", {rgt0, req0, rlt0}, 3'b010);
    @(negedge clk);

    // Reset in 2nd RUN cycle aborts without done.
    @(negedge clk);
    a0 = 16'h0F00; b0 = 16'h0E00; start0 = 1;
    @(negedge clk);
    start0 = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_res", {rgt0, req0, rlt0}, 0);
    @(negedge clk);
    rst = 0;
    runs = 0;
    for (int i = 0; i < 6; i++) begin
      if (done0) runs++;
      @(negedge clk);
    end
    chk("abort_no_done", runs, 0);
    chk("abort_res_hold", {rgt0, req0, rlt0}, 0);
    run0(16'h0100, 16'h0200, cyc, runs, cs);
    chk("post_abort_cycle", cyc, 3);
    chk("post_abort_res", {rgt0, req0, rlt0}, 3'b001);
    @(negedge clk);

    // NIBBLES=1: single RUN cycle, then back-to-back start.
    @(negedge clk);
    a1 = 4'hA; b1 = 4'h3; start1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("n1_run", {busy1, done1}, 2'b10);
    @(negedge clk);
    chk("n1_done", done1, 1);
    chk("n1_res", {rgt1, req1, rlt1}, 3'b100);
    a1 = 4'h5; b1 = 4'h5; start1 = 1;      // sampled in DONE (ignored) then IDLE (accepted)
    @(negedge clk);
    chk("n1_idle", {busy1, done1}, 2'b00);
    @(negedge clk);
    start1 = 0;
    chk("n1_b2b_run", {busy1, done1}, 2'b10);
    chk("n1_b2b_hold", {rgt1, req1, rlt1}, 3'b100);
    @(negedge clk);
    chk("n1_b2b_done", done1, 1);
    chk("n1_b2b_res", {rgt1, req1, rlt1}, 3'b010);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
